// File: rtl/scan_sequencer.sv
// Start-stop film scan controller: capture one CCD line, step the film, settle, repeat.
// Owns scan_en and drives the stepper enable/step/direction lines directly.
module scan_sequencer #(
  parameter int LINE_W = 16,
  parameter int STEP_W = 16,
  parameter int TIME_W = 24
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LINE_W-1:0] lines_total,
  input  logic [STEP_W-1:0] steps_per_line,
  input  logic [STEP_W-1:0] step_period,
  input  logic [TIME_W-1:0] settle_cycles,
  input  logic [TIME_W-1:0] timeout_cycles,
  input  logic              dir_cfg,
  input  logic              line_done,
  output logic              scan_en,
  output logic              mtr_en,
  output logic              mtr_step,
  output logic              mtr_dir,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [LINE_W-1:0] line_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ZERO    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_MOVE    = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [LINE_W-1:0] r_lines_total;
  logic [STEP_W-1:0] r_steps, r_period;
  logic [TIME_W-1:0] r_settle, r_timeout;
  logic [TIME_W-1:0] r_cnt, w_cnt_nxt;
  logic [STEP_W-1:0] r_phase_cnt, w_phase_cnt_nxt;
  logic [STEP_W-1:0] r_step_cnt, w_step_cnt_nxt;
  logic              r_step_hi, w_step_hi_nxt;
  logic              w_load;
  logic              w_err_nxt;
  logic [LINE_W-1:0] w_line_count_nxt;
  logic [LINE_W-1:0] w_lc_inc;
  logic [STEP_W-1:0] w_phase_inc, w_step_inc;
  logic              r_scan_en, r_mtr_en, r_mtr_step, r_mtr_dir, r_busy, r_done, r_err;
  logic [LINE_W-1:0] r_line_count;

  assign w_lc_inc    = r_line_count + LINE_W'(1);
  assign w_phase_inc = r_phase_cnt + STEP_W'(1);
  assign w_step_inc  = r_step_cnt + STEP_W'(1);

  // Next-state, counter and status decode; abort overrides every other event
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_phase_cnt_nxt  = r_phase_cnt;
    w_step_cnt_nxt   = r_step_cnt;
    w_step_hi_nxt    = r_step_hi;
    w_line_count_nxt = r_line_count;
    w_err_nxt        = r_err;
    w_load           = 1'b0;
    if (abort) begin
      w_state_nxt   = ST_IDLE;
      w_step_hi_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_load           = 1'b1;
            w_err_nxt        = 1'b0;
            w_line_count_nxt = LINE_W'(0);
            w_cnt_nxt        = TIME_W'(0);
            w_state_nxt      = (lines_total == LINE_W'(0)) ? ST_ZERO : ST_CAPTURE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ZERO: w_state_nxt = ST_DONE;
        ST_CAPTURE: begin
          if (line_done) begin
            w_line_count_nxt = (&r_line_count) ? r_line_count : w_lc_inc;
            w_cnt_nxt        = TIME_W'(0);
            w_phase_cnt_nxt  = STEP_W'(0);
            w_step_cnt_nxt   = STEP_W'(0);
            if (w_lc_inc == r_lines_total) begin
              w_state_nxt = ST_DONE;
            end else if (r_steps == STEP_W'(0)) begin
              w_state_nxt = ST_SETTLE;
            end else begin
              w_state_nxt   = ST_MOVE;
              w_step_hi_nxt = 1'b1;
            end
          end else if ((r_timeout != TIME_W'(0)) && (r_cnt == r_timeout)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + TIME_W'(1);
          end
        end
        ST_MOVE: begin
          if (w_phase_inc == r_period) begin
            w_phase_cnt_nxt = STEP_W'(0);
            if (r_step_hi) begin
              w_step_hi_nxt = 1'b0;
            end else if (w_step_inc == r_steps) begin
              w_state_nxt = ST_SETTLE;
              w_cnt_nxt   = TIME_W'(0);
            end else begin
              w_step_cnt_nxt = w_step_inc;
              w_step_hi_nxt  = 1'b1;
            end
          end else begin
            w_phase_cnt_nxt = w_phase_inc;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == r_settle) begin
            w_state_nxt = ST_CAPTURE;
            w_cnt_nxt   = TIME_W'(0);
          end else begin
            w_cnt_nxt = r_cnt + TIME_W'(1);
          end
        end
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, counters and configuration latched on an accepted start
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= TIME_W'(0);
      r_phase_cnt   <= STEP_W'(0);
      r_step_cnt    <= STEP_W'(0);
      r_step_hi     <= 1'b0;
      r_lines_total <= LINE_W'(0);
      r_steps       <= STEP_W'(0);
      r_period      <= STEP_W'(1);
      r_settle      <= TIME_W'(0);
      r_timeout     <= TIME_W'(0);
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_phase_cnt <= w_phase_cnt_nxt;
      r_step_cnt  <= w_step_cnt_nxt;
      r_step_hi   <= w_step_hi_nxt;
      if (w_load) begin
        r_lines_total <= lines_total;
        r_steps       <= steps_per_line;
        // A zero period would never end a phase, so it runs as one cycle
        r_period      <= (step_period == STEP_W'(0)) ? STEP_W'(1) : step_period;
        r_settle      <= settle_cycles;
        r_timeout     <= timeout_cycles;
      end
    end
  end

  // Outputs registered from the next state so they line up with it
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_scan_en    <= 1'b0;
      r_mtr_en     <= 1'b0;
      r_mtr_step   <= 1'b0;
      r_mtr_dir    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_line_count <= LINE_W'(0);
    end else begin
      r_scan_en    <= (w_state_nxt == ST_CAPTURE);
      r_mtr_en     <= (w_state_nxt == ST_MOVE) || (w_state_nxt == ST_SETTLE);
      r_mtr_step   <= (w_state_nxt == ST_MOVE) && w_step_hi_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done       <= (w_state_nxt == ST_DONE);
      r_err        <= w_err_nxt;
      r_line_count <= w_line_count_nxt;
      if (w_load) begin
        r_mtr_dir <= dir_cfg;
      end
    end
  end

  assign scan_en     = r_scan_en;
  assign mtr_en      = r_mtr_en;
  assign mtr_step    = r_mtr_step;
  assign mtr_dir     = r_mtr_dir;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_timeout = r_err;
  assign line_count  = r_line_count;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: a timeline model lists the expected output edges of each scan,
// and a monitor matches every observed output edge against that list in order.
module tb_scan_sequencer;
  localparam int LINE_W = 16;
  localparam int STEP_W = 16;
  localparam int TIME_W = 24;

  localparam int K_SCAN_RISE = 0, K_SCAN_FALL = 1, K_STEP_RISE = 2, K_STEP_FALL = 3;
  localparam int K_MEN_RISE = 4, K_MEN_FALL = 5, K_BUSY_RISE = 6, K_BUSY_FALL = 7;
  localparam int K_DONE = 8, K_ERR_RISE = 9, K_ERR_FALL = 10, K_DIR = 11, K_LC = 12;

  logic clk_100M = 1'b0;
  logic rst, start, abort, dir_cfg, line_done;
  logic [LINE_W-1:0] lines_total;
  logic [STEP_W-1:0] steps_per_line, step_period;
  logic [TIME_W-1:0] settle_cycles, timeout_cycles;
  logic scan_en, mtr_en, mtr_step, mtr_dir, busy, done, err_timeout;
  logic [LINE_W-1:0] line_count;

  scan_sequencer #(.LINE_W(LINE_W), .STEP_W(STEP_W), .TIME_W(TIME_W)) dut (
    .clk_100M(clk_100M), .rst(rst), .start(start), .abort(abort),
    .lines_total(lines_total), .steps_per_line(steps_per_line), .step_period(step_period),
    .settle_cycles(settle_cycles), .timeout_cycles(timeout_cycles), .dir_cfg(dir_cfg),
    .line_done(line_done), .scan_en(scan_en), .mtr_en(mtr_en), .mtr_step(mtr_step),
    .mtr_dir(mtr_dir), .busy(busy), .done(done), .err_timeout(err_timeout),
    .line_count(line_count)
  );

  always #5 clk_100M = ~clk_100M;

  int cyc = 0;
  always @(posedge clk_100M) cyc <= cyc + 1;

  typedef struct packed { int cyc; int kind; int val; } ev_t;
  ev_t exp_q[$];
  ev_t pl[$];
  int  ld_cyc[$];
  int  n_cmp = 0, n_fail = 0;

  int sc_L, sc_S, sc_P, sc_ST, sc_T, sc_D, sc_abort, sc_rst;
  bit sc_dir, sc_no_ld;
  bit m_err = 1'b0, m_dir = 1'b0;
  int m_lc = 0;

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Insert into the plan keeping (cycle, kind) order, which is the monitor's order
  task automatic add(input int c, input int k, input int v);
    ev_t e;
    int  i;
    e.cyc = c; e.kind = k; e.val = v;
    i = pl.size();
    while (i > 0 && (pl[i-1].cyc > c || (pl[i-1].cyc == c && pl[i-1].kind > k))) i--;
    pl.insert(i, e);
  endtask

  function automatic bit level_at(input int kr, input int kf, input int x);
    bit l = 1'b0;
    foreach (pl[i]) begin
      if (pl[i].cyc <= x) begin
        if (pl[i].kind == kr) l = 1'b1;
        else if (pl[i].kind == kf) l = 1'b0;
      end
    end
    return l;
  endfunction

  // Expected output edges of an uninterrupted scan started at cycle c0
  task automatic build_plan(input int c0);
    int pe, cs, n, lc, m;
    pl.delete();
    ld_cyc.delete();
    pe = (sc_P == 0) ? 1 : sc_P;
    lc = 0;
    add(c0 + 1, K_BUSY_RISE, 1);
    if (m_dir != sc_dir) add(c0 + 1, K_DIR, int'(sc_dir));
    if (m_err) add(c0 + 1, K_ERR_FALL, 0);
    if (m_lc != 0) add(c0 + 1, K_LC, 0);
    if (sc_L == 0) begin
      add(c0 + 2, K_DONE, 1);
      add(c0 + 3, K_BUSY_FALL, 0);
    end else begin
      cs = c0 + 1;
      while (1) begin
        add(cs, K_SCAN_RISE, 1);
        if (sc_no_ld) begin
          add(cs + sc_T + 1, K_SCAN_FALL, 0);
          add(cs + sc_T + 1, K_ERR_RISE, 1);
          add(cs + sc_T + 1, K_BUSY_FALL, 0);
          break;
        end
        n = cs + sc_D;
        ld_cyc.push_back(n);
        lc++;
        add(n + 1, K_SCAN_FALL, 0);
        add(n + 1, K_LC, lc);
        if (lc == sc_L) begin
          add(n + 1, K_DONE, 1);
          add(n + 2, K_BUSY_FALL, 0);
          break;
        end
        add(n + 1, K_MEN_RISE, 1);
        for (int k = 0; k < sc_S; k++) begin
          add(n + 1 + 2 * k * pe, K_STEP_RISE, 1);
          add(n + 1 + (2 * k + 1) * pe, K_STEP_FALL, 0);
        end
        m  = n + 1 + 2 * sc_S * pe;
        cs = m + sc_ST + 1;
        add(cs, K_MEN_FALL, 0);
      end
    end
  endtask

  // Abort (or reset) sampled at cycle a: later edges vanish, active outputs drop at a+1
  task automatic truncate(input int a, input bit is_rst);
    ev_t keep[$];
    int  ld_keep[$];
    bit  sl = 1'b0, tl = 1'b0, ml = 1'b0, bl = 1'b0, el, dl;
    int  lcl;
    el = m_err; dl = m_dir; lcl = m_lc;
    foreach (pl[i]) begin
      if (pl[i].cyc <= a) begin
        keep.push_back(pl[i]);
        case (pl[i].kind)
          K_SCAN_RISE: sl = 1'b1;
          K_SCAN_FALL: sl = 1'b0;
          K_STEP_RISE: tl = 1'b1;
          K_STEP_FALL: tl = 1'b0;
          K_MEN_RISE:  ml = 1'b1;
          K_MEN_FALL:  ml = 1'b0;
          K_BUSY_RISE: bl = 1'b1;
          K_BUSY_FALL: bl = 1'b0;
          K_ERR_RISE:  el = 1'b1;
          K_ERR_FALL:  el = 1'b0;
          K_DIR:       dl = (pl[i].val != 0);
          K_LC:        lcl = pl[i].val;
          default: ;
        endcase
      end
    end
    pl = keep;
    foreach (ld_cyc[i]) if (ld_cyc[i] <= a) ld_keep.push_back(ld_cyc[i]);
    ld_cyc = ld_keep;
    if (sl) add(a + 1, K_SCAN_FALL, 0);
    if (tl) add(a + 1, K_STEP_FALL, 0);
    if (ml) add(a + 1, K_MEN_FALL, 0);
    if (bl) add(a + 1, K_BUSY_FALL, 0);
    if (is_rst) begin
      if (el) add(a + 1, K_ERR_FALL, 0);
      if (dl) add(a + 1, K_DIR, 0);
      if (lcl != 0) add(a + 1, K_LC, 0);
    end
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, expected no event", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event_order: got kind=%0d val=%0d cycle=%0d, expected kind=%0d val=%0d cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  bit mon_on = 1'b0;
  logic p_scan = 1'b0, p_step = 1'b0, p_men = 1'b0, p_busy = 1'b0, p_err = 1'b0, p_dir = 1'b0;
  logic [LINE_W-1:0] p_lc = '0;

  // Monitor: every output edge (and every done-high cycle) consumes one expected event
  always @(negedge clk_100M) begin
    if (mon_on) begin
      if (scan_en !== p_scan)  observe(scan_en ? K_SCAN_RISE : K_SCAN_FALL, scan_en ? 1 : 0);
      if (mtr_step !== p_step) observe(mtr_step ? K_STEP_RISE : K_STEP_FALL, mtr_step ? 1 : 0);
      if (mtr_en !== p_men)    observe(mtr_en ? K_MEN_RISE : K_MEN_FALL, mtr_en ? 1 : 0);
      if (busy !== p_busy)     observe(busy ? K_BUSY_RISE : K_BUSY_FALL, busy ? 1 : 0);
      if (done !== 1'b0)       observe(K_DONE, done ? 1 : 0);
      if (err_timeout !== p_err) observe(err_timeout ? K_ERR_RISE : K_ERR_FALL, err_timeout ? 1 : 0);
      if (mtr_dir !== p_dir)   observe(K_DIR, mtr_dir ? 1 : 0);
      if (line_count !== p_lc) observe(K_LC, int'(line_count));
      p_scan = scan_en; p_step = mtr_step; p_men = mtr_en; p_busy = busy;
      p_err = err_timeout; p_dir = mtr_dir; p_lc = line_count;
    end
  end

  task automatic run_scn();
    int c0, endc, ab, rs, x;
    bit ld_at[0:1023];
    bit st_at[0:1023];
    c0 = cyc;
    build_plan(c0);
    ab = (sc_abort > 0) ? c0 + sc_abort : -1;
    rs = (sc_rst > 0) ? c0 + sc_rst : -1;
    if (ab >= 0) truncate(ab, 1'b0);
    if (rs >= 0) truncate(rs, 1'b1);
    endc = pl[pl.size()-1].cyc + 2;
    foreach (ld_at[i]) begin ld_at[i] = 1'b0; st_at[i] = 1'b0; end
    foreach (ld_cyc[i]) ld_at[ld_cyc[i] - c0] = 1'b1;
    // Spurious line_done outside CAPTURE and start while busy must have no effect
    for (int j = 0; j < 4; j++) begin
      x = c0 + 1 + int'($urandom_range(0, endc - c0 - 1));
      if (!level_at(K_SCAN_RISE, K_SCAN_FALL, x)) ld_at[x - c0] = 1'b1;
      x = c0 + 1 + int'($urandom_range(0, endc - c0 - 1));
      if (level_at(K_BUSY_RISE, K_BUSY_FALL, x)) st_at[x - c0] = 1'b1;
    end
    foreach (pl[i]) exp_q.push_back(pl[i]);
    for (int y = c0; y <= endc; y++) begin
      start     = (y == c0) || st_at[y - c0];
      abort     = (y == ab);
      rst       = (y == rs);
      line_done = ld_at[y - c0];
      if (y == c0) begin
        lines_total    = LINE_W'(sc_L);
        steps_per_line = STEP_W'(sc_S);
        step_period    = STEP_W'(sc_P);
        settle_cycles  = TIME_W'(sc_ST);
        timeout_cycles = TIME_W'(sc_T);
        dir_cfg        = sc_dir;
      end else begin
        lines_total    = LINE_W'($urandom_range(0, 7));
        steps_per_line = STEP_W'($urandom_range(0, 7));
        step_period    = STEP_W'($urandom_range(0, 7));
        settle_cycles  = TIME_W'($urandom_range(0, 7));
        timeout_cycles = TIME_W'($urandom_range(0, 7));
        dir_cfg        = 1'($urandom_range(0, 1));
      end
      tick();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; line_done = 1'b0;
    tick();
    chk("pending_events", exp_q.size(), 0);
    exp_q.delete();
    foreach (pl[i]) begin
      case (pl[i].kind)
        K_ERR_RISE: m_err = 1'b1;
        K_ERR_FALL: m_err = 1'b0;
        K_DIR:      m_dir = (pl[i].val != 0);
        K_LC:       m_lc = pl[i].val;
        default: ;
      endcase
    end
  endtask

  task automatic set_scn(input int l, input int s, input int p, input int st, input int t,
                         input int d, input bit dr, input bit nold, input int ab, input int rs);
    sc_L = l; sc_S = s; sc_P = p; sc_ST = st; sc_T = t; sc_D = d;
    sc_dir = dr; sc_no_ld = nold; sc_abort = ab; sc_rst = rs;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; line_done = 1'b0; dir_cfg = 1'b0;
    lines_total = '0; steps_per_line = '0; step_period = '0;
    settle_cycles = '0; timeout_cycles = '0;
    repeat (3) @(posedge clk_100M);
    #1;
    chk("reset_scan_en", int'(scan_en), 0);
    chk("reset_mtr_en", int'(mtr_en), 0);
    chk("reset_mtr_step", int'(mtr_step), 0);
    chk("reset_mtr_dir", int'(mtr_dir), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err_timeout), 0);
    chk("reset_line_count", int'(line_count), 0);
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (2) tick();

    set_scn(3, 2, 4, 5, 0, 10, 1'b1, 1'b0, 0, 0);  run_scn();   // normal scan
    set_scn(0, 2, 2, 2, 0, 3, 1'b0, 1'b0, 0, 0);   run_scn();   // zero lines
    set_scn(2, 0, 2, 2, 0, 3, 1'b1, 1'b0, 0, 0);   run_scn();   // zero steps
    set_scn(2, 2, 0, 1, 0, 2, 1'b0, 1'b0, 0, 0);   run_scn();   // zero period
    set_scn(3, 3, 3, 2, 0, 4, 1'b1, 1'b0, 13, 0);  run_scn();   // abort in step 1 high
    set_scn(2, 1, 1, 1, 20, 0, 1'b0, 1'b1, 0, 0);  run_scn();   // timeout
    set_scn(1, 1, 1, 0, 0, 2, 1'b1, 1'b0, 0, 0);   run_scn();   // start clears error
    set_scn(2, 1, 2, 6, 0, 3, 1'b1, 1'b0, 0, 11);  run_scn();   // reset mid-settle
    set_scn(2, 2, 1, 1, 0, 2, 1'b0, 1'b0, 0, 0);   run_scn();   // fresh scan after reset

    for (int r = 0; r < 24; r++) begin
      sc_L  = int'($urandom_range(0, 4));
      sc_S  = int'($urandom_range(0, 3));
      sc_P  = int'($urandom_range(0, 3));
      sc_ST = int'($urandom_range(0, 4));
      sc_D  = int'($urandom_range(0, 6));
      sc_dir = 1'($urandom_range(0, 1));
      sc_no_ld = ($urandom_range(0, 7) == 0);
      if (sc_no_ld) sc_T = int'($urandom_range(1, 10));
      else sc_T = ($urandom_range(0, 1) == 0) ? 0 : sc_D + 1 + int'($urandom_range(0, 8));
      sc_abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
      sc_rst = 0;
      run_scn();
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
